periph_bus_arbiter: RTL and testbench
=====================================

Name: periph_bus_arbiter

Overview:
- Shares the single peripheral/memory port (ROM window, RAM window, TTY at top word) between two masters.
  - m0: CPU load/store unit.
  - m1: DMA/debug loader.
- Arbitration is round-robin, with an m0 lock for atomic read-modify-write.
- Tracks the port's one-cycle registered read latency and routes read data back to the issuing master.
- Blocks writes into the ROM window and flags them.

Parameters:
- ADDR_W, 22, word address width of the peripheral port.
- DATA_W, 32, data width.
- ROM_TOP, 22'h1FFFFF, highest ROM word address; writes at or below it are illegal.
- MAX_HOLD, 8, maximum consecutive locked m0 grants while m1 waits (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req, m1_req  in  1  access request; held stable with its attributes until granted.
- m0_we, m1_we  in  1  1=write, 0=read.
- m0_addr, m1_addr  in  ADDR_W  word address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_lock  in  1  keep m0 ownership across consecutive grants.
- m0_gnt, m1_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid, m1_rvalid  out  1  read data valid.
- m0_rdata, m1_rdata  out  DATA_W  read data.
- m0_err, m1_err  out  1  one-cycle pulse: write to ROM window was dropped.
- p_req  out  1  peripheral request strobe.
- p_we  out  1  peripheral write enable.
- p_addr  out  ADDR_W  peripheral address.
- p_din  out  DATA_W  peripheral write data.
- p_dout  in  DATA_W  peripheral read data, registered by the port; valid the cycle after the address.

Behaviour:
- Reset (async, rst_n=0):
  - rr_last=1, so m0 wins the first tie.
  - state=FREE, hold_cnt=0, rd_pend=0, all err regs 0.
  - All outputs are 0 while in reset; gnt is forced 0.
- Arbitration is combinational each cycle, at most one grant per cycle:
  - FREE, one requester: that requester wins.
  - FREE, both requesting: the master != rr_last wins.
  - LOCKED0, m0_req=1: m0 wins unless hold_cnt==MAX_HOLD and m1_req=1, in which case m1 wins.
  - LOCKED0, m0_req=0: treated as FREE.
- On a grant:
  - rr_last <= winner.
  - p_addr and p_din mux from the winner; p_req=1; p_we=winner_we.
- Lock FSM:
  - FREE -> LOCKED0 when m0 is granted with m0_lock=1; hold_cnt <= 1.
  - LOCKED0, m0 granted with m0_lock=1: hold_cnt increments, saturating at MAX_HOLD.
  - LOCKED0 -> FREE when m0_lock=0, when m0 is not granted, or on a forced m1 grant; hold_cnt <= 0.
  - hold_cnt counts only while m1_req=1; it is cleared in any cycle with m1_req=0.
- ROM protection:
  - Applies to a granted write with addr <= ROM_TOP.
  - gnt is still asserted, but p_req=0 and p_we=0.
  - The owner's err pulses 1 the next cycle.
  - No rvalid is produced.
- Read return:
  - A granted read sets rd_pend<=1 and rd_owner<=winner.
  - The next cycle asserts mX_rvalid=1 and mX_rdata=p_dout for rd_owner.
  - The non-owner's rvalid is 0 and its rdata is 0.
  - Back-to-back reads are fully pipelined: a new grant in the return cycle is legal, giving throughput 1/cycle.
- Writes: complete in the grant cycle; there is no response other than gnt.
- TTY word (all ones): a read grant drives p_req=1 for exactly one cycle, so the TTY consumes exactly one character per read.
- No requester: p_req=0, p_we=0; p_addr and p_din hold their last values (don't-care).
- Reset asserted mid-read: pending rvalid is lost and never delivered; the master must reissue.
- Simultaneous grant and return to different masters: both are legal in the same cycle.

Test Plan:
- After reset: m0 and m1 both read 22'h000010 every cycle -> grants alternate m0,m1,m0,m1; each rvalid appears 1 cycle after the matching gnt with p_dout routed to the correct master.
- m1 writes 0xDEADBEEF to 22'h200000, then reads it back -> p_we=1 in the grant cycle; read returns 0xDEADBEEF on m1_rdata one cycle after grant.
- m0 writes to 22'h000004 -> m0_gnt=1, p_req=0, p_we=0, m0_err=1 the next cycle, no rvalid.
- m0_lock=1 with continuous m0_req and m1_req, MAX_HOLD=8 -> m0 gets 8 consecutive grants, then m1 granted on the 9th cycle, FSM back to FREE.
- m0 reads 22'h3FFFFF once -> p_req high exactly 1 cycle, m0_rvalid=1 with {24'h0,char} the next cycle.
- rst_n asserted in the cycle after a read grant -> no rvalid delivered; after release the first tie goes to m0.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for the shared peripheral/memory port: round-robin with an
// m0 atomic lock, ROM write protection and one-cycle read-return routing.
module periph_bus_arbiter #(
  parameter int unsigned        ADDR_W   = 22,
  parameter int unsigned        DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  ROM_TOP  = 22'h1FFFFF,
  parameter int unsigned        MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m0_lock_i,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m0_gnt_o,
  output logic              m1_gnt_o,
  output logic              m0_rvalid_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m0_err_o,
  output logic              m1_err_o,
  output logic              p_req_o,
  output logic              p_we_o,
  output logic [ADDR_W-1:0] p_addr_o,
  output logic [DATA_W-1:0] p_din_o,
  input  logic [DATA_W-1:0] p_dout_i
);

  typedef enum logic {FREE = 1'b0, LOCKED0 = 1'b1} state_e;

  localparam logic [7:0] HoldMax = 8'(MAX_HOLD);

  state_e            state_q, state_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic              rr_last_q, rr_last_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic              m0_err_q, m0_err_d;
  logic              m1_err_q, m1_err_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0] din_hold_q, din_hold_d;

  logic              gnt_any;
  logic              win;
  logic              forced;
  logic              win_we;
  logic              rom_hit;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Arbitration; gnt is gated by rst_n so nothing is accepted while in reset.
  always_comb begin
    gnt_any = 1'b0;
    win     = 1'b0;
    forced  = 1'b0;
    if (state_q == LOCKED0 && m0_req_i) begin
      gnt_any = 1'b1;
      forced  = (hold_cnt_q == HoldMax) && m1_req_i;
      win     = forced;
    end else if (m0_req_i && m1_req_i) begin
      gnt_any = 1'b1;
      win     = ~rr_last_q;
    end else if (m0_req_i) begin
      gnt_any = 1'b1;
      win     = 1'b0;
    end else if (m1_req_i) begin
      gnt_any = 1'b1;
      win     = 1'b1;
    end
    if (!rst_n) begin
      gnt_any = 1'b0;
    end
    win_we    = win ? m1_we_i    : m0_we_i;
    win_addr  = win ? m1_addr_i  : m0_addr_i;
    win_wdata = win ? m1_wdata_i : m0_wdata_i;
    rom_hit   = gnt_any && win_we && (win_addr <= ROM_TOP);
  end

  always_comb begin
    state_d     = FREE;
    hold_cnt_d  = '0;
    rr_last_d   = rr_last_q;
    addr_hold_d = addr_hold_q;
    din_hold_d  = din_hold_q;
    if (gnt_any) begin
      rr_last_d   = win;
      addr_hold_d = win_addr;
      din_hold_d  = win_wdata;
    end
    // A forced m1 grant leaves win=1, so it falls through to FREE here.
    if (gnt_any && !win && m0_lock_i) begin
      state_d = LOCKED0;
      if (state_q == FREE) begin
        hold_cnt_d = 8'd1;
      end else if (hold_cnt_q < HoldMax) begin
        hold_cnt_d = hold_cnt_q + 8'd1;
      end else begin
        hold_cnt_d = hold_cnt_q;
      end
    end
    if (!m1_req_i) begin
      hold_cnt_d = '0;
    end
    rd_pend_d  = gnt_any && !win_we;
    rd_owner_d = rd_pend_d ? win : rd_owner_q;
    m0_err_d   = rom_hit && !win;
    m1_err_d   = rom_hit && win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FREE;
      hold_cnt_q  <= '0;
      rr_last_q   <= 1'b1;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      addr_hold_q <= '0;
      din_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      rr_last_q   <= rr_last_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
      addr_hold_q <= addr_hold_d;
      din_hold_q  <= din_hold_d;
    end
  end

  assign m0_gnt_o    = gnt_any && !win;
  assign m1_gnt_o    = gnt_any && win;
  assign p_req_o     = gnt_any && !rom_hit;
  assign p_we_o      = p_req_o && win_we;
  assign p_addr_o    = gnt_any ? win_addr  : addr_hold_q;
  assign p_din_o     = gnt_any ? win_wdata : din_hold_q;
  assign m0_rvalid_o = rd_pend_q && !rd_owner_q;
  assign m1_rvalid_o = rd_pend_q && rd_owner_q;
  assign m0_rdata_o  = m0_rvalid_o ? p_dout_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? p_dout_i : '0;
  assign m0_err_o    = m0_err_q;
  assign m1_err_o    = m1_err_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomized bench for periph_bus_arbiter against a transaction-level reference
// model, with a small peripheral memory/TTY responding to the DUT port.
module tb_periph_bus_arbiter;
  localparam int unsigned ADDR_W   = 22;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_HOLD = 8;
  localparam logic [21:0] ROM_TOP  = 22'h1FFFFF;
  localparam logic [21:0] TTY      = 22'h3FFFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m0_req, m0_we, m0_lock, m1_req, m1_we;
  logic [21:0]       m0_addr, m1_addr;
  logic [31:0]       m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              p_req, p_we;
  logic [21:0]       p_addr;
  logic [31:0]       p_din;
  logic [31:0]       p_dout = '0;

  always #5 clk = ~clk;

  periph_bus_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ROM_TOP (ROM_TOP),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_lock_i(m0_lock),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt),
    .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
    .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
    .m0_err_o(m0_err), .m1_err_o(m1_err),
    .p_req_o(p_req), .p_we_o(p_we), .p_addr_o(p_addr), .p_din_o(p_din),
    .p_dout_i(p_dout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pending transaction per master.
  bit          rq [2];
  bit          wr [2];
  logic [21:0] ad [2];
  logic [31:0] wd [2];
  bit          lk;

  // Reference model state.
  int          m_last;
  bit          m_locked;
  int          m_hold;
  bit          e_rv  [2];
  bit          e_err [2];
  logic [31:0] e_rdata;
  logic [31:0] rmem [logic [21:0]];
  int          r_tty;

  // Peripheral behaviour seen by the DUT.
  logic [31:0] pmem [logic [21:0]];
  int          p_tty;

  bit          log_on;
  int          gnt_log [$];

  function automatic logic [31:0] fill(input logic [21:0] a);
    return {10'h2A5, a};
  endfunction

  function automatic logic [31:0] ref_read(input logic [21:0] a);
    if (a == TTY) begin
      r_tty++;
      return {24'h0, 8'(r_tty)};
    end
    return rmem.exists(a) ? rmem[a] : fill(a);
  endfunction

  function automatic logic [31:0] periph_read(input logic [21:0] a);
    if (a == TTY) begin
      p_tty++;
      return {24'h0, 8'(p_tty)};
    end
    return pmem.exists(a) ? pmem[a] : fill(a);
  endfunction

  function automatic logic [21:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 22'h000004;
      1:       return 22'h000010;
      2:       return 22'h200000;
      3:       return 22'h200001;
      4:       return TTY;
      default: return ROM_TOP;
    endcase
  endfunction

  task automatic set_req(input int i, input bit w, input logic [21:0] a, input logic [31:0] d);
    rq[i] = 1'b1; wr[i] = w; ad[i] = a; wd[i] = d;
  endtask

  task automatic drive();
    m0_req = rq[0]; m0_we = wr[0]; m0_addr = ad[0]; m0_wdata = wd[0]; m0_lock = lk;
    m1_req = rq[1]; m1_we = wr[1]; m1_addr = ad[1]; m1_wdata = wd[1];
  endtask

  task automatic model_reset();
    m_last = 1; m_locked = 1'b0; m_hold = 0;
    e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_err[0] = 1'b0; e_err[1] = 1'b0;
    e_rdata = '0;
  endtask

  // One clock cycle: entered at posedge+1, returns at the next posedge+1.
  task automatic step();
    int          w;
    bit          fr;
    bit          rom;
    bit          exp_preq;
    bit          rd_now;
    logic [31:0] nd;
    drive();
    #4;
    w = -1;
    fr = 1'b0;
    if (m_locked && rq[0]) begin
      fr = (m_hold == int'(MAX_HOLD)) && rq[1];
      w  = fr ? 1 : 0;
    end else if (rq[0] && rq[1]) begin
      w = (m_last == 0) ? 1 : 0;
    end else if (rq[0]) begin
      w = 0;
    end else if (rq[1]) begin
      w = 1;
    end
    rom      = (w >= 0) && wr[w] && (ad[w] <= ROM_TOP);
    exp_preq = (w >= 0) && !rom;

    check("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
    check("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
    check("m0_rdata", m0_rdata, e_rv[0] ? e_rdata : 32'h0);
    check("m1_rdata", m1_rdata, e_rv[1] ? e_rdata : 32'h0);
    check("m0_err", 32'(m0_err), 32'(e_err[0]));
    check("m1_err", 32'(m1_err), 32'(e_err[1]));
    check("m0_gnt", 32'(m0_gnt), 32'(w == 0));
    check("m1_gnt", 32'(m1_gnt), 32'(w == 1));
    check("p_req", 32'(p_req), 32'(exp_preq));
    check("p_we", 32'(p_we), 32'(exp_preq && wr[w]));
    if (exp_preq) check("p_addr", 32'(p_addr), 32'(ad[w]));
    if (exp_preq && wr[w]) check("p_din", p_din, wd[w]);
    if (log_on && w >= 0) gnt_log.push_back(m1_gnt ? 1 : (m0_gnt ? 0 : -1));

    rd_now = p_req && !p_we;
    nd = '0;
    if (rd_now) nd = periph_read(p_addr);
    if (p_req && p_we) pmem[p_addr] = p_din;

    e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_err[0] = 1'b0; e_err[1] = 1'b0;
    if (w >= 0) begin
      if (wr[w]) begin
        if (rom) e_err[w] = 1'b1;
        else     rmem[ad[w]] = wd[w];
      end else begin
        e_rv[w] = 1'b1;
        e_rdata = ref_read(ad[w]);
      end
      m_last = w;
    end
    if (w == 0 && lk) begin
      if (!rq[1])        m_hold = 0;
      else if (!m_locked) m_hold = 1;
      else if (m_hold < int'(MAX_HOLD)) m_hold++;
      m_locked = 1'b1;
    end else begin
      m_locked = 1'b0;
      m_hold   = 0;
    end
    if (w >= 0) rq[w] = 1'b0;

    @(posedge clk);
    #1;
    p_dout = rd_now ? nd : $urandom;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, 22'h000010, '0);
    set_req(1, 1'b0, 22'h000010, '0);
    lk = 1'b1;
    drive();
    #4;
    check("rst_m0_gnt", 32'(m0_gnt), 32'h0);
    check("rst_m1_gnt", 32'(m1_gnt), 32'h0);
    check("rst_p_req", 32'(p_req), 32'h0);
    check("rst_p_we", 32'(p_we), 32'h0);
    check("rst_p_addr", 32'(p_addr), 32'h0);
    check("rst_p_din", p_din, 32'h0);
    check("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'h0);
    check("rst_rdata0", m0_rdata, 32'h0);
    check("rst_rdata1", m1_rdata, 32'h0);
    check("rst_err", 32'({m0_err, m1_err}), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rq[0] = 1'b0; rq[1] = 1'b0; lk = 1'b0;
    model_reset();
  endtask

  initial begin
    int lead;
    rst_n = 1'b0;
    r_tty = 0; p_tty = 0; log_on = 1'b0;
    rq[0] = 1'b0; rq[1] = 1'b0; lk = 1'b0;
    model_reset();
    drive();
    @(posedge clk); #1;
    apply_reset();

    // Both masters reading the same ROM word: strict alternation, m0 first.
    for (int c = 0; c < 12; c++) begin
      if (!rq[0]) set_req(0, 1'b0, 22'h000010, '0);
      if (!rq[1]) set_req(1, 1'b0, 22'h000010, '0);
      step();
    end
    step();

    // RAM write then read-back, ROM write rejection, TTY read.
    set_req(1, 1'b1, 22'h200000, 32'hDEADBEEF);
    step();
    set_req(1, 1'b0, 22'h200000, '0);
    step();
    set_req(0, 1'b1, 22'h000004, 32'h12345678);
    step();
    set_req(0, 1'b1, ROM_TOP, 32'h0BADF00D);
    step();
    set_req(0, 1'b1, 22'h200000 - 22'h0 , 32'h5A5A0001);
    step();
    set_req(0, 1'b0, TTY, '0);
    step();
    step();

    // Lock starvation bound: from reset, m0 gets MAX_HOLD grants then m1.
    apply_reset();
    log_on = 1'b1;
    gnt_log.delete();
    for (int c = 0; c < 24; c++) begin
      lk = 1'b1;
      if (!rq[0]) set_req(0, 1'b0, 22'h200001, '0);
      if (!rq[1]) set_req(1, 1'b0, 22'h200000, '0);
      step();
    end
    log_on = 1'b0;
    lk = 1'b0;
    lead = 0;
    while (lead < gnt_log.size() && gnt_log[lead] == 0) lead++;
    check("lock_run_len", 32'(lead), 32'(MAX_HOLD));
    check("lock_then_m1", (lead < gnt_log.size()) ? 32'(gnt_log[lead]) : 32'hFFFFFFFF, 32'h1);
    step();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq[i] && $urandom_range(0, 9) < 7)
          set_req(i, $urandom_range(0, 2) == 0, pick_addr(), $urandom);
      end
      lk = ($urandom_range(0, 3) != 0);
      step();
    end
    lk = 1'b0;
    step();
    step();

    // Reset in the return cycle of a read: no rvalid, then m0 wins the first tie.
    set_req(0, 1'b0, 22'h200001, '0);
    step();
    apply_reset();
    set_req(0, 1'b0, 22'h000010, '0);
    set_req(1, 1'b0, 22'h000010, '0);
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
